// File: rtl/dynamic_digit_scanner_pkg.sv
// Shared definitions for the digit scan engine and the seven-segment pattern decoder.
package dynamic_digit_scanner_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_SCAN,
    ST_GAP
  } scan_state_e;

endpackage

// File: rtl/scan_dwell_counter.sv
// Terminal-count counter with clear. done is high while the count sits at TERMINAL-1.
module scan_dwell_counter #(
  parameter int TERMINAL = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign done = (count_q == CNT_W'(TERMINAL - 1));

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    count_d = count_q;
    if (clear)   count_d = '0;
    else if (en) count_d = done ? '0 : count_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/dynamic_digit_scanner.sv
// Time-multiplexed digit scan engine with a one-deep frame buffer.
// Optional blinking of selected positions is enabled by defining DIGIT_BLINK_EN.
module dynamic_digit_scanner
  import dynamic_digit_scanner_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 2
`ifdef DIGIT_BLINK_EN
  ,
  parameter int BLINK_SHIFT = 4
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         loadValid,
  output logic                         loadReady,
  input  logic [CODE_W*NUM_DIGITS-1:0] loadData,
  output logic [CODE_W-1:0]            dynamicDigit,
  output logic [NUM_DIGITS-1:0]        digitSelect,
  output logic                         frameStart
`ifdef DIGIT_BLINK_EN
  ,
  input  logic [NUM_DIGITS-1:0]        blinkMask
`endif
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] frame_t;

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  frame_t                pend_q, pend_d, disp_q, disp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [CODE_W-1:0]     digit_q, digit_d;
  logic                  fs_q, fs_d;
  logic [NUM_DIGITS-1:0] blink_kill;
  logic                  dwell_done, gap_done, frame_edge;

  scan_dwell_counter #(.TERMINAL(SCAN_DIV)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != ST_SCAN),
    .en    (state_q == ST_SCAN),
    .done  (dwell_done)
  );

  scan_dwell_counter #(.TERMINAL(GAP_CYCLES)) u_gap (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != ST_GAP),
    .en    (state_q == ST_GAP),
    .done  (gap_done)
  );

  // Leaving the last position is the only point where a new frame may be committed.
  assign frame_edge = (state_q == ST_SCAN) && dwell_done && (idx_q == LAST_IDX);

`ifdef DIGIT_BLINK_EN
  localparam int FC_W = BLINK_SHIFT + 1;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_edge ? frame_cnt_q + FC_W'(1) : frame_cnt_q;
  assign blink_kill  = frame_cnt_d[BLINK_SHIFT] ? blinkMask : '0;

  always_ff @(posedge clk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end
`else
  assign blink_kill = '0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;

    if (loadValid && !pend_valid_q) begin
      pend_d       = loadData;
      pend_valid_d = 1'b1;
    end

    unique case (state_q)
      ST_BLANK: begin
        if (pend_valid_q) begin
          state_d      = ST_SCAN;
          disp_d       = pend_q;
          pend_valid_d = 1'b0;
          idx_d        = '0;
        end
      end
      ST_SCAN: begin
        if (dwell_done) begin
          state_d = ST_GAP;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          if (frame_edge && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
          end
        end
      end
      ST_GAP:  if (gap_done) state_d = ST_SCAN;
      default: state_d = ST_BLANK;
    endcase

    // Outputs are derived from next state so the registered ports line up with the state they describe.
    sel_d   = (state_d == ST_SCAN) ? ((NUM_DIGITS'(1) << idx_d) & ~blink_kill) : '0;
    digit_d = (state_d == ST_BLANK) ? '0 : disp_d[idx_d];
    fs_d    = (state_d == ST_SCAN) && (state_q != ST_SCAN) && (idx_d == '0);
  end

  // NOTE: the frame buffers are a few flops, so they are reset outright rather than left undefined.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
      sel_q        <= '0;
      digit_q      <= '0;
      fs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      disp_q       <= disp_d;
      sel_q        <= sel_d;
      digit_q      <= digit_d;
      fs_q         <= fs_d;
    end
  end

  assign loadReady    = !pend_valid_q;
  assign digitSelect  = sel_q;
  assign dynamicDigit = digit_q;
  assign frameStart   = fs_q;

endmodule

// File: tb/tb_dynamic_digit_scanner.sv
// Scoreboard bench: each scenario queues the expected per-cycle outputs, then pops and compares them.
module tb_dynamic_digit_scanner;

  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] dig;
    logic       fs;
    logic       rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [8:0] load_data = '0;
  logic       load_ready;
  logic [2:0] dyn_digit;
  logic [2:0] digit_sel;
  logic       frame_start;
  logic [2:0] blink_mask = '0;

  logic       reset_f = 1'b1;
  logic       load_valid_f = 1'b0;
  logic [8:0] load_data_f = '0;
  logic       load_ready_f;
  logic [2:0] dyn_digit_f;
  logic [2:0] digit_sel_f;
  logic       frame_start_f;
  logic [2:0] blink_mask_f = '0;

  exp_t q_main[$];
  exp_t q_fast[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [8:0] DATA_D = 9'b010_001_111;
  localparam logic [8:0] DATA_A = 9'b101_011_110;
  localparam logic [8:0] DATA_B = 9'b000_110_100;
  localparam logic [8:0] DATA_C = 9'b111_111_111;
  localparam logic [8:0] DATA_F = 9'b011_101_001;
  localparam logic [8:0] DATA_G = 9'b110_010_101;

  always #5 clk = ~clk;

  dynamic_digit_scanner #(
    .NUM_DIGITS (3),
    .SCAN_DIV   (4),
    .GAP_CYCLES (1)
`ifdef DIGIT_BLINK_EN
    ,
    .BLINK_SHIFT(0)
`endif
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .loadValid    (load_valid),
    .loadReady    (load_ready),
    .loadData     (load_data),
    .dynamicDigit (dyn_digit),
    .digitSelect  (digit_sel),
    .frameStart   (frame_start)
`ifdef DIGIT_BLINK_EN
    ,
    .blinkMask    (blink_mask)
`endif
  );

  dynamic_digit_scanner #(
    .NUM_DIGITS (3),
    .SCAN_DIV   (1),
    .GAP_CYCLES (1)
  ) u_dut_fast (
    .clk          (clk),
    .reset        (reset_f),
    .loadValid    (load_valid_f),
    .loadReady    (load_ready_f),
    .loadData     (load_data_f),
    .dynamicDigit (dyn_digit_f),
    .digitSelect  (digit_sel_f),
    .frameStart   (frame_start_f)
`ifdef DIGIT_BLINK_EN
    ,
    .blinkMask    (blink_mask_f)
`endif
  );

  task automatic push_exp(input int which, input exp_t e);
    if (which == 0) q_main.push_back(e);
    else            q_fast.push_back(e);
  endtask

  // Expected outputs for one frame showing `cur`; the final gap already shows `nxt` position 0.
  // rdy bit k is the expected loadReady at frame offset k; only the first `len` cycles are queued.
  task automatic push_frame(input int which, input logic [8:0] cur, input logic [8:0] nxt,
                            input int sd, input int gc, input logic [31:0] rdy,
                            input logic [2:0] kill, input int len);
    exp_t e;
    int   k = 0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < sd; c++) begin
        e.sel = kill[p] ? 3'b000 : 3'(1 << p);
        e.dig = cur[3*p +: 3];
        e.fs  = (p == 0) && (c == 0);
        e.rdy = rdy[k];
        if (k < len) push_exp(which, e);
        k++;
      end
      for (int c = 0; c < gc; c++) begin
        e.sel = 3'b000;
        e.dig = (p == 2) ? nxt[2:0] : cur[3*(p+1) +: 3];
        e.fs  = 1'b0;
        e.rdy = rdy[k];
        if (k < len) push_exp(which, e);
        k++;
      end
    end
  endtask

  task automatic push_blank(input int which, input int n, input logic rdy);
    exp_t e;
    e = '{sel: 3'b000, dig: 3'b000, fs: 1'b0, rdy: rdy};
    for (int i = 0; i < n; i++) push_exp(which, e);
  endtask

  task automatic test_reset();
    exp_t e;
    push_blank(0, 21, 1'b1);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      e = q_main.pop_front();
      n_cmp++;
      if ({digit_sel, dyn_digit, frame_start, load_ready} !== {e.sel, e.dig, e.fs, e.rdy}) begin
        n_err++;
        $display("FAIL reset cyc %0d: got sel=%b dig=%b fs=%b rdy=%b want sel=%b dig=%b fs=%b rdy=%b",
                 k, digit_sel, dyn_digit, frame_start, load_ready, e.sel, e.dig, e.fs, e.rdy);
      end
      reset = 1'b0;
    end
  endtask

  task automatic test_first_load();
    exp_t e;
    push_blank(0, 1, 1'b0);
    push_frame(0, DATA_D, DATA_D, 4, 1, '1, 3'b000, 15);
    push_frame(0, DATA_D, DATA_D, 4, 1, '1, 3'b000, 15);
    load_valid = 1'b1;
    load_data  = DATA_D;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = q_main.pop_front();
      n_cmp++;
      if ({digit_sel, dyn_digit, frame_start, load_ready} !== {e.sel, e.dig, e.fs, e.rdy}) begin
        n_err++;
        $display("FAIL first_load cyc %0d: got sel=%b dig=%b fs=%b rdy=%b want sel=%b dig=%b fs=%b rdy=%b",
                 k, digit_sel, dyn_digit, frame_start, load_ready, e.sel, e.dig, e.fs, e.rdy);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    push_frame(0, DATA_D, DATA_A, 4, 1, 32'h0000_4007, 3'b000, 15);
    push_frame(0, DATA_A, DATA_B, 4, 1, 32'h0000_4000, 3'b000, 15);
    push_frame(0, DATA_B, DATA_B, 4, 1, '1, 3'b000, 15);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      e = q_main.pop_front();
      n_cmp++;
      if ({digit_sel, dyn_digit, frame_start, load_ready} !== {e.sel, e.dig, e.fs, e.rdy}) begin
        n_err++;
        $display("FAIL back_to_back cyc %0d: got sel=%b dig=%b fs=%b rdy=%b want sel=%b dig=%b fs=%b rdy=%b",
                 k, digit_sel, dyn_digit, frame_start, load_ready, e.sel, e.dig, e.fs, e.rdy);
      end
      if (k == 2) begin
        load_valid = 1'b1;
        load_data  = DATA_A;
      end
      if (k == 3)  load_data  = DATA_B;
      if (k == 15) load_valid = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    push_frame(0, DATA_B, DATA_B, 4, 1, 32'h0000_0003, 3'b000, 6);
    push_blank(0, 21, 1'b1);
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      e = q_main.pop_front();
      n_cmp++;
      if ({digit_sel, dyn_digit, frame_start, load_ready} !== {e.sel, e.dig, e.fs, e.rdy}) begin
        n_err++;
        $display("FAIL mid_reset cyc %0d: got sel=%b dig=%b fs=%b rdy=%b want sel=%b dig=%b fs=%b rdy=%b",
                 k, digit_sel, dyn_digit, frame_start, load_ready, e.sel, e.dig, e.fs, e.rdy);
      end
      if (k == 1) begin
        load_valid = 1'b1;
        load_data  = DATA_C;
      end
      if (k == 2) load_valid = 1'b0;
      if (k == 5) reset = 1'b1;
      if (k == 6) reset = 1'b0;
    end
  endtask

`ifdef DIGIT_BLINK_EN
  task automatic test_blink();
    exp_t e;
    blink_mask = 3'b010;
    push_blank(0, 1, 1'b0);
    for (int f = 0; f < 4; f++)
      push_frame(0, DATA_F, DATA_F, 4, 1, '1, (f % 2 == 1) ? 3'b010 : 3'b000, 15);
    load_valid = 1'b1;
    load_data  = DATA_F;
    for (int k = 0; k < 61; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = q_main.pop_front();
      n_cmp++;
      if ({digit_sel, dyn_digit, frame_start, load_ready} !== {e.sel, e.dig, e.fs, e.rdy}) begin
        n_err++;
        $display("FAIL blink cyc %0d: got sel=%b dig=%b fs=%b rdy=%b want sel=%b dig=%b fs=%b rdy=%b",
                 k, digit_sel, dyn_digit, frame_start, load_ready, e.sel, e.dig, e.fs, e.rdy);
      end
    end
    blink_mask = 3'b000;
  endtask
`endif

  task automatic test_fast_scan();
    exp_t e;
    @(negedge clk);
    reset_f = 1'b0;
    push_blank(1, 1, 1'b0);
    push_frame(1, DATA_G, DATA_G, 1, 1, '1, 3'b000, 6);
    push_frame(1, DATA_G, DATA_G, 1, 1, '1, 3'b000, 6);
    load_valid_f = 1'b1;
    load_data_f  = DATA_G;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      load_valid_f = 1'b0;
      e = q_fast.pop_front();
      n_cmp++;
      if ({digit_sel_f, dyn_digit_f, frame_start_f, load_ready_f} !== {e.sel, e.dig, e.fs, e.rdy}) begin
        n_err++;
        $display("FAIL fast_scan cyc %0d: got sel=%b dig=%b fs=%b rdy=%b want sel=%b dig=%b fs=%b rdy=%b",
                 k, digit_sel_f, dyn_digit_f, frame_start_f, load_ready_f, e.sel, e.dig, e.fs, e.rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_back_to_back();
    test_mid_reset();
`ifdef DIGIT_BLINK_EN
    test_blink();
`endif
    test_fast_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
